// File: rtl/halflife_sequencer.sv
// halflife_sequencer: loads an initial activity into the decay counter, then
// issues one decay step per half-life period until the value reaches zero.
// Keeps a shadow of the counter value and the number of half-lives elapsed.
module halflife_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [3:0] init_val,
    input  logic [7:0] period,
    output logic       ctr_load,
    output logic [3:0] ctr_in,
    output logic       ctr_step,
    output logic [3:0] value,
    output logic [2:0] halvings,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] tick;
    logic [7:0] period_q;
    logic       accept;
    logic       fire;

    // Strobes and status are pure state decodes, so no input reaches an output
    // combinationally.
    assign ctr_load = (state == LOAD);
    assign busy     = (state == LOAD) || (state == RUN);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort outranks everything, including a due step.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = LOAD;
                        accept    = 1'b1;
                    end
                end
                LOAD: state_nxt = (value == 4'd0) ? DONE : RUN;
                RUN: begin
                    if (!pause && tick == 8'd0) begin
                        fire = 1'b1;
                        // The step that shifts the last set bit out lands in DONE.
                        if (value[3:1] == 3'd0) state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: capture on start, half-life timer, shadow value and step strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick     <= 8'd0;
            period_q <= 8'd0;
            ctr_in   <= 4'd0;
            value    <= 4'd0;
            halvings <= 3'd0;
            ctr_step <= 1'b0;
        end else if (abort) begin
            value    <= 4'd0;
            halvings <= 3'd0;
            ctr_in   <= 4'd0;
            ctr_step <= 1'b0;
        end else begin
            ctr_step <= fire;
            if (accept) begin
                ctr_in   <= init_val;
                value    <= init_val;
                halvings <= 3'd0;
                period_q <= period;
                tick     <= period;
            end else if (state == RUN && !pause) begin
                if (fire) begin
                    value    <= value >> 1;
                    halvings <= halvings + 3'd1;
                    tick     <= period_q;
                end else begin
                    tick <= tick - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_halflife_sequencer.sv
// Self-checking bench for halflife_sequencer: scenario table, randomized runs
// against a cycle-count reference model, and hand-written abort/reset sequences.
module tb_halflife_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, pause;
    logic [3:0] init_val;
    logic [7:0] period;
    logic       ctr_load, ctr_step, busy, done;
    logic [3:0] ctr_in, value;
    logic [2:0] halvings;

    int checks = 0;
    int errors = 0;

    halflife_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .init_val(init_val), .period(period), .ctr_load(ctr_load), .ctr_in(ctr_in),
        .ctr_step(ctr_step), .value(value), .halvings(halvings), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iv;
        int pr;
        int plo;
        int phi;
        int first_step;
        int first_done;
        int final_halv;
    } vec_t;

    task automatic chk(input string nm, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm, input int c);
        chk({nm, ".busy"}, c, busy, 0);
        chk({nm, ".done"}, c, done, 0);
        chk({nm, ".value"}, c, value, 0);
        chk({nm, ".halvings"}, c, halvings, 0);
        chk({nm, ".ctr_step"}, c, ctr_step, 0);
        chk({nm, ".ctr_load"}, c, ctr_load, 0);
        chk({nm, ".ctr_in"}, c, ctr_in, 0);
    endtask

    // Reference: each step needs period+1 unpaused RUN cycles (RUN begins in
    // cycle 2), and the step is visible the cycle after the last one of them.
    // The number of steps is the bit length of init_val.
    task automatic run_seq(input int iv, input int pr, input int plo, input int phi,
                           input bit rnd, output int first_step, output int first_done,
                           output int final_halv);
        int steps[$];
        int n, v, u, c, k, last, cnt;
        bit exp_step;
        n = 0; v = iv;
        while (v != 0) begin v = v >> 1; n++; end
        u = 0; c = 2; k = 1;
        while (k <= n) begin
            if (!(c >= plo && c <= phi)) begin
                u++;
                if (u == k * (pr + 1)) begin steps.push_back(c + 1); k++; end
            end
            c++;
        end
        last = (n == 0) ? 2 : steps[n-1];

        first_step = 0; first_done = 0;
        start = 1'b0; pause = 1'b0; abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        for (int cy = 0; cy <= last + 3; cy++) begin
            start    = (cy == 0) || (rnd && cy >= 1 && cy < last && $urandom_range(3) == 0);
            init_val = (cy == 0 || !rnd) ? 4'(iv) : 4'($urandom);
            period   = (cy == 0 || !rnd) ? 8'(pr) : 8'($urandom);
            pause    = (cy >= plo && cy <= phi);
            @(negedge clk);
            if (cy == 0) begin
                chk_zero("idle", cy);
            end else begin
                cnt = 0; exp_step = 1'b0;
                foreach (steps[i]) begin
                    if (steps[i] <= cy) cnt++;
                    if (steps[i] == cy) exp_step = 1'b1;
                end
                chk("ctr_load", cy, ctr_load, cy == 1);
                chk("ctr_in", cy, ctr_in, iv);
                chk("ctr_step", cy, ctr_step, exp_step);
                chk("value", cy, value, iv >> cnt);
                chk("halvings", cy, halvings, cnt);
                chk("busy", cy, busy, cy < last);
                chk("done", cy, done, cy >= last);
                if (ctr_step && first_step == 0) first_step = cy;
                if (done && first_done == 0) first_done = cy;
            end
            next_cycle();
        end
        final_halv = halvings;
        start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        vec_t vecs[4];
        int fs, fd, fh, strobes;

        vecs[0] = '{iv: 12, pr: 3, plo: 0, phi: -1, first_step: 6, first_done: 18, final_halv: 4};
        vecs[1] = '{iv: 0,  pr: 5, plo: 0, phi: -1, first_step: 0, first_done: 2,  final_halv: 0};
        vecs[2] = '{iv: 15, pr: 0, plo: 0, phi: -1, first_step: 3, first_done: 6,  final_halv: 4};
        vecs[3] = '{iv: 8,  pr: 2, plo: 3, phi: 6,  first_step: 9, first_done: 18, final_halv: 4};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        init_val = 4'd0; period = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset", 0);
        rst_n = 1'b1;
        next_cycle();

        // Directed scenarios
        foreach (vecs[i]) begin
            run_seq(vecs[i].iv, vecs[i].pr, vecs[i].plo, vecs[i].phi, 1'b0, fs, fd, fh);
            chk("tbl.first_step", i, fs, vecs[i].first_step);
            chk("tbl.first_done", i, fd, vecs[i].first_done);
            chk("tbl.final_halv", i, fh, vecs[i].final_halv);
        end

        // Randomized runs with stray starts, input churn and pause windows
        for (int r = 0; r < 30; r++) begin
            int lo;
            lo = $urandom_range(15, 1);
            run_seq($urandom_range(15), $urandom_range(6), lo, lo + $urandom_range(5) - 1,
                    1'b1, fs, fd, fh);
        end

        // Abort together with start in cycle 7
        abort = 1'b1; next_cycle(); abort = 1'b0;
        init_val = 4'd12; period = 8'd3; start = 1'b1;
        for (int cy = 0; cy < 7; cy++) begin
            next_cycle();
            start = 1'b0;
        end
        @(negedge clk);
        chk("abort.pre_value", 7, value, 6);
        abort = 1'b1; start = 1'b1;
        next_cycle();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_zero("abort", 8);
        strobes = 0;
        for (int cy = 0; cy < 20; cy++) begin
            next_cycle();
            @(negedge clk);
            strobes += int'(ctr_step) + int'(ctr_load) + int'(busy) + int'(done);
        end
        chk("abort.quiet", 28, strobes, 0);
        next_cycle();
        init_val = 4'd5; period = 8'd1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("restart.ctr_load", 1, ctr_load, 1);
        chk("restart.ctr_in", 1, ctr_in, 5);

        // Asynchronous reset in mid-RUN
        next_cycle();
        abort = 1'b1; next_cycle(); abort = 1'b0;
        init_val = 4'd12; period = 8'd3; start = 1'b1;
        for (int cy = 0; cy < 8; cy++) begin
            next_cycle();
            start = 1'b0;
        end
        @(negedge clk);
        chk("rst.pre_busy", 8, busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst", 8);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int cy = 0; cy < 10; cy++) begin
            next_cycle();
            @(negedge clk);
            strobes += int'(ctr_step) + int'(ctr_load) + int'(busy) + int'(done);
        end
        chk("rst.quiet", 0, strobes, 0);
        next_cycle();
        init_val = 4'd8; period = 8'd1; start = 1'b1;
        next_cycle();
        start = 1'b0; period = 8'd9;
        @(negedge clk);
        chk("rst.ctr_load", 1, ctr_load, 1);
        for (int cy = 2; cy <= 4; cy++) begin
            next_cycle();
            @(negedge clk);
            chk("rst.ctr_step", cy, ctr_step, cy == 4);
        end
        chk("rst.value", 4, value, 4);
        chk("rst.halvings", 4, halvings, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
